// File: rtl/imem_sync_loadable.sv
// imem_sync_loadable: registered-read instruction memory with clear-after-reset, program-load port and fetch fault flags.
// Define IMEM_PARITY_EN to store an even-parity bit per word and report mismatches on parity_err.
module imem_sync_loadable #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   input  logic              fetch_req,
   input  logic              stall,
   input  logic              ld_en,
   input  logic [IDX_W-1:0]  ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] instruction,
   output logic              instr_valid,
   output logic              fetch_fault,
   output logic              init_busy,
   output logic              parity_err
);
   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;
`ifdef IMEM_PARITY_EN
   localparam int W = DATA_W + 1;
`else
   localparam int W = DATA_W;
`endif
   logic [W-1:0]     mem [DEPTH];
   logic [0:0]       state;
   logic [IDX_W-1:0] clr_idx;
   logic [IDX_W-1:0] idx;
   logic             fault;
   logic             hit;
   logic [W-1:0]     ld_word;
   logic [W-1:0]     rd_word;
   // upper pc bits only feed the range check, never the index
   assign idx       = pc[IDX_W+1:2];
   assign fault     = (|pc[1:0]) || ((pc >> 2) >= ADDR_W'(DEPTH));
   assign hit       = ld_en && ld_addr == idx;
`ifdef IMEM_PARITY_EN
   assign ld_word   = {^ld_data, ld_data};
`else
   assign ld_word   = ld_data;
`endif
   assign rd_word   = hit ? ld_word : mem[idx];
   assign init_busy = state == CLEAR;
   always_ff @(posedge clk) begin
      if (state == CLEAR) mem[clr_idx] <= '0;
      else if (ld_en) mem[ld_addr] <= ld_word;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else if (state == CLEAR) begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == IDX_W'(DEPTH - 1)) state <= RUN;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruction <= '0;
         instr_valid <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (state == CLEAR) begin
         instr_valid <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (!stall) begin
         instr_valid <= fetch_req;
         fetch_fault <= fetch_req && fault;
         if (fetch_req) instruction <= fault ? '0 : rd_word[DATA_W-1:0];
      end
   end
`ifdef IMEM_PARITY_EN
   logic par_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) par_q <= 1'b0;
      else if (state == RUN && !stall) par_q <= fetch_req && !fault && (^rd_word);
   end
   assign parity_err = par_q;
`else
   assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_imem_sync_loadable.sv
// tb_imem_sync_loadable: directed plus random fetch/load traffic checked against an array-based reference model.
module tb_imem_sync_loadable;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = '0;
   logic        fetch_req = 1'b0;
   logic        stall = 1'b0;
   logic        ld_en = 1'b0;
   logic [6:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        fetch_fault;
   logic        init_busy;
   logic        parity_err;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_mem [128];
   bit          m_bad [128];
   int          m_busy;
   logic [31:0] e_instr;
   logic        e_valid, e_fault, e_par;

   imem_sync_loadable dut (
      .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .stall(stall),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .instruction(instruction),
      .instr_valid(instr_valid), .fetch_fault(fetch_fault), .init_busy(init_busy),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 128; i++) begin
         m_mem[i] = '0;
         m_bad[i] = 1'b0;
      end
      m_busy  = 128;
      e_instr = '0;
      e_valid = 1'b0;
      e_fault = 1'b0;
      e_par   = 1'b0;
   endtask

   task automatic model_edge();
      int  w;
      bit  f;
      if (m_busy > 0) begin
         m_busy--;
         e_valid = 1'b0;
         e_fault = 1'b0;
         return;
      end
      if (ld_en) begin
         m_mem[ld_addr] = ld_data;
         m_bad[ld_addr] = 1'b0;
      end
      if (stall) return;
      if (fetch_req) begin
         w = int'(pc / 4);
         f = (pc % 4 != 0) || (w >= 128);
         e_valid = 1'b1;
         e_fault = f;
         e_instr = f ? 32'h0 : m_mem[w];
         e_par   = !f && m_bad[w];
      end else begin
         e_valid = 1'b0;
         e_fault = 1'b0;
         e_par   = 1'b0;
      end
   endtask

   task automatic check_outs();
      chk("instr", instruction, e_instr);
      chk("valid", 32'(instr_valid), 32'(e_valid));
      chk("fault", 32'(fetch_fault), 32'(e_fault));
      chk("busy", 32'(init_busy), 32'(m_busy > 0));
      chk("parity", 32'(parity_err), 32'(e_par));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic idle();
      fetch_req = 1'b0;
      stall     = 1'b0;
      ld_en     = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_outs();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic count_busy(string tag);
      int n = 0;
      while (init_busy && n < 1000) begin
         cycle();
         n++;
      end
      chk(tag, 32'(n), 32'd128);
   endtask

   task automatic rand_stim();
      int sel = $urandom_range(0, 99);
      fetch_req = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      ld_en     = ($urandom_range(0, 9) < 3);
      ld_data   = $urandom;
      if (sel < 60) pc = 32'($urandom_range(0, 127)) * 4;
      else if (sel < 75) pc = 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3));
      else if (sel < 90) pc = 32'($urandom_range(128, 2000)) * 4;
      else pc = $urandom;
      ld_addr = ($urandom_range(0, 3) == 0) ? 7'((pc / 4) % 128) : 7'($urandom_range(0, 127));
   endtask

   initial begin
      idle();
      do_reset();
      count_busy("busy_cycles");
      fetch_req = 1'b1;
      pc = 32'h0;
      cycle();
      chk("first_fetch", instruction, 32'h0);
      chk("first_valid", 32'(instr_valid), 32'd1);
      idle();
      ld_en = 1'b1; ld_addr = 7'd1; ld_data = 32'h20090037;
      cycle();
      ld_en = 1'b0; fetch_req = 1'b1; pc = 32'h4;
      cycle();
      chk("load_fetch", instruction, 32'h20090037);
      chk("load_fault", 32'(fetch_fault), 32'd0);
      ld_en = 1'b1; ld_addr = 7'd2; ld_data = 32'h01098024; pc = 32'h8;
      cycle();
      ld_en = 1'b0;
      chk("bypass", instruction, 32'h01098024);
      pc = 32'h6;
      cycle();
      chk("misalign_instr", instruction, 32'h0);
      chk("misalign_fault", 32'(fetch_fault), 32'd1);
      pc = 32'h200;
      cycle();
      chk("range_fault", 32'(fetch_fault), 32'd1);
      chk("range_valid", 32'(instr_valid), 32'd1);
      pc = 32'h4;
      cycle();
      stall = 1'b1; pc = 32'h8;
      repeat (3) cycle();
      chk("stall_hold", instruction, 32'h20090037);
      stall = 1'b0; fetch_req = 1'b0;
      cycle();
      chk("idle_valid", 32'(instr_valid), 32'd0);
      ld_en = 1'b1; ld_addr = 7'd3; ld_data = 32'hdeadbeef;
      do_reset();
      repeat (50) cycle();
      do_reset();
      count_busy("busy_cycles_rst");
      chk("clear_after_rst", m_mem[3], 32'h0);
`ifdef IMEM_PARITY_EN
      ld_en = 1'b1; ld_addr = 7'd1; ld_data = 32'h20090037;
      cycle();
      idle();
      dut.mem[1][32] = ~dut.mem[1][32];
      m_bad[1] = 1'b1;
      fetch_req = 1'b1; pc = 32'h4;
      cycle();
      chk("parity_flip", 32'(parity_err), 32'd1);
      idle();
`endif
      for (int i = 0; i < 3000; i++) begin
         rand_stim();
         cycle();
      end
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
